// File: rtl/fft_butterfly_comp_if.sv
// Sample/result bus of the FFT butterfly: mode select, four complex inputs, four complex outputs.
interface fft_butterfly_comp_if #(
  parameter int unsigned BIT = 17
);
  logic                  iBUT_SEL;
  logic signed [BIT-1:0] iX0_RE, iX0_IM, iX1_RE, iX1_IM;
  logic signed [BIT-1:0] iX2_RE, iX2_IM, iX3_RE, iX3_IM;
  logic signed [BIT-1:0] oY0_RE, oY0_IM, oY1_RE, oY1_IM;
  logic signed [BIT-1:0] oY2_RE, oY2_IM, oY3_RE, oY3_IM;

  modport master (
    output iBUT_SEL,
    output iX0_RE, iX0_IM, iX1_RE, iX1_IM, iX2_RE, iX2_IM, iX3_RE, iX3_IM,
    input  oY0_RE, oY0_IM, oY1_RE, oY1_IM, oY2_RE, oY2_IM, oY3_RE, oY3_IM
  );

  modport slave (
    input  iBUT_SEL,
    input  iX0_RE, iX0_IM, iX1_RE, iX1_IM, iX2_RE, iX2_IM, iX3_RE, iX3_IM,
    output oY0_RE, oY0_IM, oY1_RE, oY1_IM, oY2_RE, oY2_IM, oY3_RE, oY3_IM
  );
endinterface

// File: rtl/fft_butterfly_comp.sv
// Registered radix-4 / dual radix-2 complex butterfly with built-in scaling (/4, /2).
// Optional FFT_BUT_ROUND_EN: round-half-up before the scaling shift; otherwise floor truncation.
module fft_butterfly_comp #(
  parameter int unsigned BIT = 17
) (
  input logic                iCLK,
  input logic                iRESET,
  fft_butterfly_comp_if.slave bus
);
  localparam int unsigned W4 = BIT + 2;
  localparam int unsigned W2 = BIT + 1;

`ifdef FFT_BUT_ROUND_EN
  localparam logic signed [W4-1:0] RND4 = W4'(2);
  localparam logic signed [W2-1:0] RND2 = W2'(1);
`else
  localparam logic signed [W4-1:0] RND4 = '0;
  localparam logic signed [W2-1:0] RND2 = '0;
`endif

  function automatic logic signed [W4-1:0] ext4(input logic signed [BIT-1:0] v);
    return {{2{v[BIT-1]}}, v};
  endfunction

  function automatic logic signed [W2-1:0] ext2(input logic signed [BIT-1:0] v);
    return {v[BIT-1], v};
  endfunction

  // Full-precision sum cannot overflow, so the scaled value always fits BIT bits.
  function automatic logic signed [BIT-1:0] scale4(input logic signed [W4-1:0] s);
    logic signed [W4-1:0] t;
    t = s + RND4;
    return BIT'(t >>> 2);
  endfunction

  function automatic logic signed [BIT-1:0] scale2(input logic signed [W2-1:0] s);
    logic signed [W2-1:0] t;
    t = s + RND2;
    return BIT'(t >>> 1);
  endfunction

  logic signed [BIT-1:0] xr [4];
  logic signed [BIT-1:0] xi [4];
  logic signed [BIT-1:0] y_re_d [4];
  logic signed [BIT-1:0] y_im_d [4];
  logic signed [BIT-1:0] y_re_q [4];
  logic signed [BIT-1:0] y_im_q [4];

  assign xr[0] = bus.iX0_RE;
  assign xi[0] = bus.iX0_IM;
  assign xr[1] = bus.iX1_RE;
  assign xi[1] = bus.iX1_IM;
  assign xr[2] = bus.iX2_RE;
  assign xi[2] = bus.iX2_IM;
  assign xr[3] = bus.iX3_RE;
  assign xi[3] = bus.iX3_IM;

  // Butterfly arithmetic for the mode presented this cycle.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      y_re_d[k] = '0;
      y_im_d[k] = '0;
    end
    if (bus.iBUT_SEL) begin
      y_re_d[0] = scale2(ext2(xr[0]) + ext2(xr[1]));
      y_im_d[0] = scale2(ext2(xi[0]) + ext2(xi[1]));
      y_re_d[1] = scale2(ext2(xr[0]) - ext2(xi[1]));
      y_im_d[1] = scale2(ext2(xi[0]) - ext2(xr[1]));
      y_re_d[2] = scale2(ext2(xr[2]) + ext2(xr[3]));
      y_im_d[2] = scale2(ext2(xi[2]) + ext2(xi[3]));
      y_re_d[3] = scale2(ext2(xr[2]) - ext2(xi[3]));
      y_im_d[3] = scale2(ext2(xi[2]) - ext2(xr[3]));
    end else begin
      y_re_d[0] = scale4(ext4(xr[0]) + ext4(xr[1]) + ext4(xr[2]) + ext4(xr[3]));
      y_im_d[0] = scale4(ext4(xi[0]) + ext4(xi[1]) + ext4(xi[2]) + ext4(xi[3]));
      y_re_d[1] = scale4(ext4(xr[0]) + ext4(xi[1]) - ext4(xr[2]) - ext4(xi[3]));
      y_im_d[1] = scale4(ext4(xi[0]) - ext4(xr[1]) - ext4(xi[2]) + ext4(xr[3]));
      y_re_d[2] = scale4(ext4(xr[0]) - ext4(xr[1]) + ext4(xr[2]) - ext4(xr[3]));
      y_im_d[2] = scale4(ext4(xi[0]) - ext4(xi[1]) + ext4(xi[2]) - ext4(xi[3]));
      y_re_d[3] = scale4(ext4(xr[0]) - ext4(xi[1]) - ext4(xr[2]) + ext4(xi[3]));
      y_im_d[3] = scale4(ext4(xi[0]) + ext4(xr[1]) - ext4(xi[2]) - ext4(xr[3]));
    end
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      for (int k = 0; k < 4; k++) begin
        y_re_q[k] <= '0;
        y_im_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        y_re_q[k] <= y_re_d[k];
        y_im_q[k] <= y_im_d[k];
      end
    end
  end

  assign bus.oY0_RE = y_re_q[0];
  assign bus.oY0_IM = y_im_q[0];
  assign bus.oY1_RE = y_re_q[1];
  assign bus.oY1_IM = y_im_q[1];
  assign bus.oY2_RE = y_re_q[2];
  assign bus.oY2_IM = y_im_q[2];
  assign bus.oY3_RE = y_re_q[3];
  assign bus.oY3_IM = y_im_q[3];

endmodule

// File: tb/tb_fft_butterfly_comp.sv
// Self-checking bench for fft_butterfly_comp: directed cases plus random mode-switching stream.
module tb_fft_butterfly_comp;
  localparam int unsigned BIT = 17;

`ifdef FFT_BUT_ROUND_EN
  localparam int RND4 = 2;
  localparam int RND2 = 1;
`else
  localparam int RND4 = 0;
  localparam int RND2 = 0;
`endif

  logic iclk;
  logic irst_n;

  fft_butterfly_comp_if #(.BIT(BIT)) bus ();

  fft_butterfly_comp #(.BIT(BIT)) dut (
    .iCLK   (iclk),
    .iRESET (irst_n),
    .bus    (bus)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  int total = 0;
  int bad   = 0;
  int xr [4];
  int xi [4];
  int er [4];
  int ei [4];
  int orr [4];
  int oi [4];
  bit sel;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.iBUT_SEL = sel;
    bus.iX0_RE = BIT'(xr[0]);
    bus.iX0_IM = BIT'(xi[0]);
    bus.iX1_RE = BIT'(xr[1]);
    bus.iX1_IM = BIT'(xi[1]);
    bus.iX2_RE = BIT'(xr[2]);
    bus.iX2_IM = BIT'(xi[2]);
    bus.iX3_RE = BIT'(xr[3]);
    bus.iX3_IM = BIT'(xi[3]);
  endtask

  task automatic sample();
    orr[0] = int'(bus.oY0_RE);
    oi[0]  = int'(bus.oY0_IM);
    orr[1] = int'(bus.oY1_RE);
    oi[1]  = int'(bus.oY1_IM);
    orr[2] = int'(bus.oY2_RE);
    oi[2]  = int'(bus.oY2_IM);
    orr[3] = int'(bus.oY3_RE);
    oi[3]  = int'(bus.oY3_IM);
  endtask

  // Reference: radix-4 as a 4-point DFT with kernel (-j)^(n*k); radix-2 from its pair formulas.
  task automatic model();
    int sr;
    int si;
    int p;
    if (!sel) begin
      for (int k = 0; k < 4; k++) begin
        sr = 0;
        si = 0;
        for (int n = 0; n < 4; n++) begin
          p = (n * k) % 4;
          case (p)
            0: begin sr += xr[n];  si += xi[n];  end
            1: begin sr += xi[n];  si -= xr[n];  end
            2: begin sr -= xr[n];  si -= xi[n];  end
            default: begin sr -= xi[n]; si += xr[n]; end
          endcase
        end
        er[k] = (sr + RND4) >>> 2;
        ei[k] = (si + RND4) >>> 2;
      end
    end else begin
      for (int b = 0; b < 4; b += 2) begin
        er[b]   = (xr[b] + xr[b+1] + RND2) >>> 1;
        ei[b]   = (xi[b] + xi[b+1] + RND2) >>> 1;
        er[b+1] = (xr[b] - xi[b+1] + RND2) >>> 1;
        ei[b+1] = (xi[b] - xr[b+1] + RND2) >>> 1;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    sample();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_y%0d_re", tag, k), orr[k], 0);
      chk($sformatf("%s_y%0d_im", tag, k), oi[k], 0);
    end
  endtask

  // Called just after a falling edge: apply inputs, check one rising edge later, return at next falling edge.
  task automatic step(input string tag);
    drive();
    model();
    @(posedge iclk);
    #1;
    sample();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_y%0d_re", tag, k), orr[k], er[k]);
      chk($sformatf("%s_y%0d_im", tag, k), oi[k], ei[k]);
    end
    @(negedge iclk);
  endtask

  task automatic rand_inputs();
    for (int n = 0; n < 4; n++) begin
      xr[n] = int'($urandom_range(65536)) - 32768;
      xi[n] = int'($urandom_range(65536)) - 32768;
    end
  endtask

  initial begin
    irst_n = 1'b0;
    sel = 1'b0;
    rand_inputs();
    drive();
    #12;
    check_zero("rst_async");
    @(negedge iclk);
    irst_n = 1'b1;
    #1;
    check_zero("rst_release_hold");

    sel = 1'b0;
    for (int n = 0; n < 4; n++) begin xr[n] = 1000; xi[n] = 0; end
    step("r4_dc");
    chk("r4_dc_y0re_const", orr[0], 1000);
    chk("r4_dc_y1re_const", orr[1], 0);

    for (int n = 0; n < 4; n++) begin xr[n] = 0; xi[n] = 0; end
    xr[0] = 100;
    xi[0] = 200;
    step("r4_imp");
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("r4_imp_y%0d_const", k), orr[k] * 1000 + oi[k], 25 * 1000 + 50);
    end

    for (int n = 0; n < 4; n++) begin xr[n] = -1; xi[n] = 0; end
    step("r4_neg1");
    chk("r4_neg1_y0re_const", orr[0], -1);
    chk("r4_neg1_y3re_const", orr[3], 0);

    for (int n = 0; n < 4; n++) begin xr[n] = -32768; xi[n] = 32767; end
    step("r4_ext");
    chk("r4_ext_y0re_const", orr[0], -32768);
    chk("r4_ext_y0im_const", oi[0], 32767);

    sel = 1'b1;
    xr[0] = 10; xi[0] = 20;
    xr[1] = 4;  xi[1] = 6;
    xr[2] = -7; xi[2] = 3;
    xr[3] = 5;  xi[3] = -9;
    step("r2");
    chk("r2_y0re_const", orr[0], 7);
    chk("r2_y0im_const", oi[0], 13);
    chk("r2_y1re_const", orr[1], 2);
    chk("r2_y1im_const", oi[1], 8);
    chk("r2_y2re_const", orr[2], -1);
    chk("r2_y2im_const", oi[2], -3);
    chk("r2_y3re_const", orr[3], 1);
    chk("r2_y3im_const", oi[3], -1);

    for (int c = 0; c < 48; c++) begin
      sel = c[0];
      rand_inputs();
      step($sformatf("sw%0d", c));
    end

    // Reset asserted mid-cycle while data keeps streaming.
    sel = 1'b0;
    rand_inputs();
    drive();
    @(posedge iclk);
    #3;
    irst_n = 1'b0;
    #1;
    check_zero("rst_mid");
    @(negedge iclk);
    irst_n = 1'b1;
    #1;
    check_zero("rst_mid_hold");
    rand_inputs();
    sel = 1'b1;
    step("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
